branch_cmp_seq: RTL and testbench
=================================

Name: branch_cmp_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle branch comparator. Takes two operands and a RISC-V branch funct3, and compares them one SLICE-bit slice per cycle, starting at the most significant slice. It stops early at the first slice that differs, then returns eq, lt and the branch-taken decision. It sits in the EX stage for wide-datapath and area-reduced configurations, and uses a valid/ready handshake on both sides plus a pipeline flush.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of SLICE.
SLICE, 8, bits compared per cycle; 1 <= SLICE <= WIDTH.
NSLICE, WIDTH/SLICE, derived slice count; not to be overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  abort any in-flight comparison.
in_valid  in  1  operands and funct3 valid.
in_ready  out  1  block can accept a request.
src1  in  WIDTH  operand A.
src2  in  WIDTH  operand B.
funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
br_eq  out  1  src1 == src2.
br_lt  out  1  src1 < src2, signed or unsigned according to funct3[1].
taken  out  1  branch-taken decision.
bad_op  out  1  funct3 was 010 or 011.

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE; in_ready=1; out_valid=0; br_eq=0; br_lt=0; taken=0; bad_op=0; slice index=NSLICE-1.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: latch src1, src2, funct3; set idx=NSLICE-1; go to CMP.
- CMP:
  - in_ready=0.
  - Each cycle compare slice idx of the latched A and B.
  - Signed ops (funct3[1]=0) invert bit WIDTH-1 of both operands before comparing; unsigned ops do not.
  - Slices differ: br_eq=0; br_lt=(A slice < B slice) as unsigned; go to DONE.
  - Slices equal and idx==0: br_eq=1; br_lt=0; go to DONE.
  - Slices equal otherwise: idx decrements; stay in CMP.
- Latency:
  - Let k = 1 + number of equal slices above the first differing slice, capped at NSLICE.
  - out_valid rises k cycles after the accepting edge. Minimum 1, maximum NSLICE.
  - No combinational path from inputs to outputs.
- DONE:
  - out_valid=1; br_eq, br_lt, taken, bad_op are stable.
  - Stays in DONE while out_ready=0.
  - When out_ready=1: go to IDLE next cycle.
  - in_ready stays 0 in DONE. Back-to-back throughput is one request per k+2 cycles.
- taken (registered together with br_eq and br_lt):
  - BEQ: eq.
  - BNE: !eq.
  - BLT / BLTU: lt.
  - BGE / BGEU: !lt.
  - 010 / 011: taken=0, bad_op=1. The comparison still runs normally and br_eq/br_lt are valid.
- Output hold: br_eq, br_lt, taken, bad_op hold their last values in IDLE. They are only meaningful while out_valid=1.
- flush:
  - From any state, go to IDLE on the next edge; out_valid=0; the result is discarded.
  - If flush and in_valid are both high in IDLE, flush wins: the request is not accepted.
  - flush in DONE while out_ready=1: the handshake is considered complete, then IDLE.
- rst has priority over flush. rst mid-CMP or mid-DONE returns all outputs to their reset values.
- SLICE==WIDTH degenerates to a fixed 1-cycle latency. SLICE==1 gives a bit-serial comparator with latency up to WIDTH cycles.
- Operand changes while not in IDLE are ignored, since operands are latched on accept.

Test Plan:
- WIDTH=32, SLICE=8: BEQ, src1=src2=0x12345678 -> out_valid 4 cycles after accept; br_eq=1, br_lt=0, taken=1.
- BLT, src1=0xFFFFFFFF (-1), src2=0x00000001 -> k=1; br_lt=1, taken=1. Same operands with BLTU -> br_lt=0, taken=0.
- BGEU, src1=0x12340000, src2=0x1234FFFF -> k=3; br_lt=1, br_eq=0, taken=0. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- funct3=010, src1=5, src2=5 -> bad_op=1, taken=0, br_eq=1.
- Start BNE with equal operands, assert flush in the 2nd CMP cycle -> IDLE next cycle, out_valid never rises, in_ready=1. Then a new BNE 1 vs 2 completes with taken=1.
- Assert rst in DONE with out_valid=1 -> next cycle out_valid=0, in_ready=1, all result outputs 0. Repeat a scenario with SLICE=32 (k=1) and SLICE=1 (BEQ on equal operands gives k=32).

Source files
------------

// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle RISC-V branch comparator.
// Compares latched operands one SLICE-bit slice per cycle, most significant
// slice first, and stops at the first slice that differs. Signed compares
// are turned into unsigned ones by flipping the operand sign bits on accept.
module branch_cmp_seq #(
  parameter int WIDTH  = 32,
  parameter int SLICE  = 8,
  parameter int NSLICE = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [2:0]       funct3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_eq,
  output logic             br_lt,
  output logic             taken,
  output logic             bad_op
);

  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
  localparam logic [IDXW-1:0]  IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0]  IDX_ONE  = IDXW'(1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [2:0]        f3_r;
  logic [IDXW-1:0]   idx_r;

  logic [SLICE-1:0]  sa_s;
  logic [SLICE-1:0]  sb_s;
  logic              diff_s;
  logic              lt_s;
  logic              last_s;

  // Branch decision from the final eq/lt result; illegal funct3 never branches.
  function automatic logic calc_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      3'b000:  t = eq;
      3'b001:  t = ~eq;
      3'b100:  t = lt;
      3'b101:  t = ~lt;
      3'b110:  t = lt;
      3'b111:  t = ~lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // funct3 010 and 011 are not branch encodings.
  function automatic logic calc_bad(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  // Select and compare the current slice of the latched operands.
  always_comb begin
    sa_s   = a_r[int'(idx_r) * SLICE +: SLICE];
    sb_s   = b_r[int'(idx_r) * SLICE +: SLICE];
    diff_s = (sa_s != sb_s);
    lt_s   = (sa_s < sb_s);
    last_s = (idx_r == IDX_ZERO);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      br_eq     <= 1'b0;
      br_lt     <= 1'b0;
      taken     <= 1'b0;
      bad_op    <= 1'b0;
      idx_r     <= IDX_TOP;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      f3_r      <= 3'b000;
    end else if (flush) begin
      // Abort whatever is in flight; the result registers keep their values.
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      idx_r     <= IDX_TOP;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Flipping the sign bit maps signed order onto unsigned order.
            a_r      <= funct3[1] ? src1 : (src1 ^ MSB_MASK);
            b_r      <= funct3[1] ? src2 : (src2 ^ MSB_MASK);
            f3_r     <= funct3;
            idx_r    <= IDX_TOP;
            in_ready <= 1'b0;
            state_r  <= CMP;
          end else begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end
        end
        CMP: begin
          if (diff_s || last_s) begin
            br_eq     <= ~diff_s;
            br_lt     <= diff_s & lt_s;
            taken     <= calc_taken(f3_r, ~diff_s, diff_s & lt_s);
            bad_op    <= calc_bad(f3_r);
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            idx_r   <= idx_r - IDX_ONE;
            state_r <= CMP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          idx_r     <= IDX_TOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed testbench for branch_cmp_seq: three instances (SLICE 8, 32, 1)
// share clock, reset, flush and out_ready; each has its own in_valid.
module tb_branch_cmp_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        out_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [2:0]  funct3;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  eq;
  logic [2:0]  lt;
  logic [2:0]  tk;
  logic [2:0]  bo;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          dut;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    logic        eq;
    logic        lt;
    logic        tk;
    logic        bo;
    int          hold;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  branch_cmp_seq #(.WIDTH(32), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .src1(src1), .src2(src2), .funct3(funct3), .out_valid(ov[0]), .out_ready(out_ready),
    .br_eq(eq[0]), .br_lt(lt[0]), .taken(tk[0]), .bad_op(bo[0]));

  branch_cmp_seq #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .src1(src1), .src2(src2), .funct3(funct3), .out_valid(ov[1]), .out_ready(out_ready),
    .br_eq(eq[1]), .br_lt(lt[1]), .taken(tk[1]), .bad_op(bo[1]));

  branch_cmp_seq #(.WIDTH(32), .SLICE(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .src1(src1), .src2(src2), .funct3(funct3), .out_valid(ov[2]), .out_ready(out_ready),
    .br_eq(eq[2]), .br_lt(lt[2]), .taken(tk[2]), .bad_op(bo[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock step; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input string nm);
    chk($sformatf("%s in_ready before accept", nm), 32'(ir[d]), 32'd1);
    funct3 = f3;
    src1   = a;
    src2   = b;
    iv[d]  = 1'b1;
    step();
    iv[d]  = 1'b0;
    src1   = ~a;
    src2   = b ^ 32'h5A5A5A5A;
    chk($sformatf("%s in_ready after accept", nm), 32'(ir[d]), 32'd0);
  endtask

  task automatic wait_done(input int d, input int k, input string nm);
    int c;
    c = 0;
    while (ov[d] !== 1'b1 && c < 40) begin
      step();
      c++;
    end
    chk($sformatf("%s latency", nm), 32'(c), 32'(k));
  endtask

  task automatic chk_res(input int d, input vec_t v, input string nm);
    chk($sformatf("%s out_valid", nm), 32'(ov[d]), 32'd1);
    chk($sformatf("%s in_ready", nm), 32'(ir[d]), 32'd0);
    chk($sformatf("%s br_eq", nm), 32'(eq[d]), 32'(v.eq));
    chk($sformatf("%s br_lt", nm), 32'(lt[d]), 32'(v.lt));
    chk($sformatf("%s taken", nm), 32'(tk[d]), 32'(v.tk));
    chk($sformatf("%s bad_op", nm), 32'(bo[d]), 32'(v.bo));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int d;
    d = v.dut;
    start(d, v.f3, v.a, v.b, nm);
    wait_done(d, v.k, nm);
    chk_res(d, v, nm);
    for (int h = 1; h <= v.hold; h++) begin
      step();
      chk_res(d, v, $sformatf("%s hold%0d", nm, h));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("%s out_valid after handshake", nm), 32'(ov[d]), 32'd0);
    chk($sformatf("%s in_ready after handshake", nm), 32'(ir[d]), 32'd1);
    chk($sformatf("%s br_eq held in idle", nm), 32'(eq[d]), 32'(v.eq));
    chk($sformatf("%s taken held in idle", nm), 32'(tk[d]), 32'(v.tk));
  endtask

  initial begin
    vec_t v;
    int   seen;

    //          dut f3      src1          src2          k  eq    lt    tk    bo    hold
    vecs[0]  = '{0, 3'b000, 32'h12345678, 32'h12345678, 4, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[1]  = '{0, 3'b100, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[2]  = '{0, 3'b110, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{0, 3'b111, 32'h12340000, 32'h1234FFFF, 3, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[4]  = '{0, 3'b010, 32'h00000005, 32'h00000005, 4, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vecs[5]  = '{0, 3'b101, 32'hFFFFFFFB, 32'h00000003, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{0, 3'b101, 32'h00000100, 32'h80000000, 1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[7]  = '{0, 3'b110, 32'h00FF0000, 32'h00FE0000, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[8]  = '{0, 3'b011, 32'h00000003, 32'h00000007, 4, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[9]  = '{0, 3'b000, 32'h000000AB, 32'h000000AC, 4, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[10] = '{1, 3'b100, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[11] = '{1, 3'b000, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[12] = '{2, 3'b000, 32'hCAFEF00D, 32'hCAFEF00D, 32, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[13] = '{2, 3'b100, 32'h40000000, 32'h60000000, 3, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[14] = '{2, 3'b110, 32'h80000000, 32'h7FFFFFFF, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; iv = 3'b000;
    src1 = 32'h0; src2 = 32'h0; funct3 = 3'b000;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state of every instance.
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset d%0d in_ready", d), 32'(ir[d]), 32'd1);
      chk($sformatf("reset d%0d out_valid", d), 32'(ov[d]), 32'd0);
      chk($sformatf("reset d%0d results", d), {28'd0, eq[d], lt[d], tk[d], bo[d]}, 32'd0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      step();
    end

    // Flush in the second CMP cycle of a BNE on equal operands.
    start(0, 3'b001, 32'h55555555, 32'h55555555, "flush");
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush out_valid", 32'(ov[0]), 32'd0);
    chk("flush in_ready", 32'(ir[0]), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ov[0] !== 1'b0) seen++;
    end
    chk("flush out_valid never rises", 32'(seen), 32'd0);
    v = '{0, 3'b001, 32'h00000001, 32'h00000002, 4, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    run_vec(v, "bne after flush");

    // flush beats in_valid in IDLE: the request is dropped.
    funct3 = 3'b000; src1 = 32'h1; src2 = 32'h1;
    iv[0] = 1'b1; flush = 1'b1;
    step();
    iv[0] = 1'b0; flush = 1'b0;
    chk("flush+in_valid in_ready", 32'(ir[0]), 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ov[0] !== 1'b0) seen++;
    end
    chk("flush+in_valid no result", 32'(seen), 32'd0);

    // Reset while DONE returns everything to reset values.
    start(0, 3'b011, 32'h00000003, 32'h00000007, "rst in done");
    wait_done(0, 4, "rst in done");
    chk("rst in done pre br_lt", 32'(lt[0]), 32'd1);
    chk("rst in done pre bad_op", 32'(bo[0]), 32'd1);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst in done out_valid", 32'(ov[0]), 32'd0);
    chk("rst in done in_ready", 32'(ir[0]), 32'd1);
    chk("rst in done results", {28'd0, eq[0], lt[0], tk[0], bo[0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
